// File: rtl/regbus_pkg.sv
// rtl/regbus_pkg.sv - shared types, limits and helpers for the register-bus arbiter
package regbus_pkg;

  localparam int MAX_PORTS = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    ACK
  } arb_state_t;

  // Index width that never collapses to zero bits.
  function automatic int clog2(input int n);
    int r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/regbus_arbiter_if.sv
// rtl/regbus_arbiter_if.sv - requester and register-file bundle of the arbiter
// REGBUS_ARB_LOCK_EN adds the per-port i_lock input.
interface regbus_arbiter_if #(
  parameter int N_PORTS      = 2,
  parameter int R_ADDR_WIDTH = 2
);

  logic [N_PORTS-1:0]              i_req;
  logic [N_PORTS-1:0]              i_we;
  logic [N_PORTS*R_ADDR_WIDTH-1:0] i_addr;
  logic [N_PORTS*32-1:0]           i_wdata;
`ifdef REGBUS_ARB_LOCK_EN
  logic [N_PORTS-1:0]              i_lock;
`endif
  logic [N_PORTS-1:0]              o_ack;
  logic [31:0]                     o_rdata;
  logic [R_ADDR_WIDTH-1:0]         o_rreg;
  logic                            o_rd;
  logic [31:0]                     i_rdata;
  logic [R_ADDR_WIDTH-1:0]         o_wreg;
  logic [31:0]                     o_wdata;
  logic                            o_wr;

`ifdef REGBUS_ARB_LOCK_EN
  modport slave (
    input  i_req, i_we, i_addr, i_wdata, i_lock, i_rdata,
    output o_ack, o_rdata, o_rreg, o_rd, o_wreg, o_wdata, o_wr
  );
  modport master (
    output i_req, i_we, i_addr, i_wdata, i_lock, i_rdata,
    input  o_ack, o_rdata, o_rreg, o_rd, o_wreg, o_wdata, o_wr
  );
`else
  modport slave (
    input  i_req, i_we, i_addr, i_wdata, i_rdata,
    output o_ack, o_rdata, o_rreg, o_rd, o_wreg, o_wdata, o_wr
  );
  modport master (
    output i_req, i_we, i_addr, i_wdata, i_rdata,
    input  o_ack, o_rdata, o_rreg, o_rd, o_wreg, o_wdata, o_wr
  );
`endif

endinterface

// File: rtl/regbus_rr_pick.sv
// rtl/regbus_rr_pick.sv - combinational round-robin picker, first request above last_grant
module regbus_rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic          any,
  output logic [IW-1:0] grant
);

  logic [IW-1:0] idx;

  always_comb begin
    any   = 1'b0;
    grant = '0;
    idx   = '0;
    // k = N revisits last_grant itself, so a lone requester always wins.
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(last_grant) + k) % N);
      if (!any && req[idx]) begin
        any   = 1'b1;
        grant = idx;
      end
    end
  end

endmodule

// File: rtl/regbus_arbiter.sv
// rtl/regbus_arbiter.sv - round-robin sharing of one register-file port, grant/access/ack
// REGBUS_ARB_LOCK_EN enables lock-owner priority for atomic read-modify-write.
module regbus_arbiter
  import regbus_pkg::*;
#(
  parameter int N_PORTS      = 2,
  parameter int R_ADDR_WIDTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  regbus_arbiter_if.slave   bus
);

  localparam int            IW         = clog2(N_PORTS);
  localparam logic [IW-1:0] LAST_RESET = IW'(N_PORTS - 1);

  generate
    if (N_PORTS < 2 || N_PORTS > MAX_PORTS) begin : g_bad_n_ports
      $error("regbus_arbiter: N_PORTS must be within 2..8");
    end
  endgenerate

  arb_state_t              state;
  logic [IW-1:0]           last_grant;
  logic [IW-1:0]           gnt;
  logic                    is_write;
  logic [N_PORTS-1:0]      ack_q;
  logic                    rd_q;
  logic                    wr_q;
  logic [R_ADDR_WIDTH-1:0] rreg_q;
  logic [R_ADDR_WIDTH-1:0] wreg_q;
  logic [31:0]             wdata_q;
  logic [31:0]             rdata_q;

  logic                    rr_any;
  logic [IW-1:0]           rr_grant;
  logic [IW-1:0]           win;
  logic                    win_locked;

  regbus_rr_pick #(
    .N  (N_PORTS),
    .IW (IW)
  ) u_pick (
    .req        (bus.i_req),
    .last_grant (last_grant),
    .any        (rr_any),
    .grant      (rr_grant)
  );

`ifdef REGBUS_ARB_LOCK_EN
  logic          lock_valid;
  logic [IW-1:0] lock_owner;

  // A requesting lock owner pre-empts round robin without moving the pointer.
  always_comb begin
    win_locked = lock_valid && bus.i_req[lock_owner];
    win        = win_locked ? lock_owner : rr_grant;
  end
`else
  always_comb begin
    win_locked = 1'b0;
    win        = rr_grant;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= LAST_RESET;
      gnt        <= '0;
      is_write   <= 1'b0;
      ack_q      <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      rreg_q     <= '0;
      wreg_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
`ifdef REGBUS_ARB_LOCK_EN
      lock_valid <= 1'b0;
      lock_owner <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
`ifdef REGBUS_ARB_LOCK_EN
          if (lock_valid && !bus.i_req[lock_owner]) lock_valid <= 1'b0;
`endif
          if (rr_any) begin
            gnt      <= win;
            is_write <= bus.i_we[win];
            rreg_q   <= bus.i_addr[win*R_ADDR_WIDTH +: R_ADDR_WIDTH];
            wreg_q   <= bus.i_addr[win*R_ADDR_WIDTH +: R_ADDR_WIDTH];
            if (!win_locked) last_grant <= win;
            if (bus.i_we[win]) begin
              wdata_q <= bus.i_wdata[win*32 +: 32];
              wr_q    <= 1'b1;
            end else begin
              rd_q    <= 1'b1;
            end
`ifdef REGBUS_ARB_LOCK_EN
            lock_owner <= win;
            lock_valid <= bus.i_lock[win];
`endif
            state <= ACCESS;
          end
        end
        ACCESS: begin
          rd_q  <= 1'b0;
          wr_q  <= 1'b0;
          if (!is_write) rdata_q <= bus.i_rdata;
          ack_q <= N_PORTS'(1) << gnt;
          state <= ACK;
        end
        ACK: begin
          ack_q <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_ack   = ack_q;
  assign bus.o_rd    = rd_q;
  assign bus.o_wr    = wr_q;
  assign bus.o_rreg  = rreg_q;
  assign bus.o_wreg  = wreg_q;
  assign bus.o_wdata = wdata_q;
  assign bus.o_rdata = rdata_q;

endmodule

// File: tb/tb_regbus_arbiter.sv
// tb/tb_regbus_arbiter.sv - self-checking bench for regbus_arbiter, 4 ports
// REGBUS_ARB_LOCK_EN also exercises lock ownership.
module tb_regbus_arbiter;

  localparam int NP = 4;

  logic clk;
  logic reset;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  logic [31:0] rf [4];

  regbus_arbiter_if #(.N_PORTS(NP), .R_ADDR_WIDTH(2)) bus ();

  regbus_arbiter #(.N_PORTS(NP), .R_ADDR_WIDTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.i_rdata = bus.o_rd ? rf[bus.o_rreg] : 32'h0BAD_F00D;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level reference: a granted access shows its strobe one cycle
  // later and its ack the cycle after that; the winner is the next requester
  // above the previous winner.
  bit          model_ok = 0;
  int          m_phase, m_g, m_last, winner;
  bit          m_wr, locked;
  logic [NP-1:0] e_ack;
  bit          e_rd, e_wr;
  logic [1:0]  e_reg;
  logic [31:0] e_wdata, e_rdata;
`ifdef REGBUS_ARB_LOCK_EN
  bit          m_lock_v;
  int          m_lock_o;
`endif

  always @(posedge clk) begin
    if (reset) begin
      model_ok = 1;
      m_phase = 0; m_last = NP - 1; m_g = 0; m_wr = 0;
      e_ack = '0; e_rd = 0; e_wr = 0; e_reg = '0; e_wdata = '0; e_rdata = '0;
`ifdef REGBUS_ARB_LOCK_EN
      m_lock_v = 0; m_lock_o = 0;
`endif
    end else if (m_phase == 0) begin
      winner = -1;
      locked = 0;
`ifdef REGBUS_ARB_LOCK_EN
      if (m_lock_v && !bus.i_req[m_lock_o]) m_lock_v = 0;
      if (m_lock_v) begin
        winner = m_lock_o;
        locked = 1;
      end
`endif
      for (int k = 1; k <= NP; k++)
        if (winner < 0 && bus.i_req[(m_last + k) % NP]) winner = (m_last + k) % NP;
      if (winner >= 0) begin
        if (!locked) m_last = winner;
        m_g   = winner;
        m_wr  = bus.i_we[winner];
        e_reg = bus.i_addr[winner*2 +: 2];
        if (m_wr) begin
          e_wr    = 1;
          e_wdata = bus.i_wdata[winner*32 +: 32];
        end else begin
          e_rd = 1;
        end
`ifdef REGBUS_ARB_LOCK_EN
        m_lock_v = bus.i_lock[winner];
        m_lock_o = winner;
`endif
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (!m_wr) e_rdata = rf[e_reg];
      e_rd = 0;
      e_wr = 0;
      e_ack = NP'(1) << m_g;
      m_phase = 2;
    end else begin
      e_ack = '0;
      m_phase = 0;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("ack", 32'(bus.o_ack), 32'(e_ack));
      check("rd", 32'(bus.o_rd), 32'(e_rd));
      check("wr", 32'(bus.o_wr), 32'(e_wr));
      check("rdata", bus.o_rdata, e_rdata);
      check("wdata", bus.o_wdata, e_wdata);
      check("rd_wr_exclusive", 32'(bus.o_rd & bus.o_wr), 32'd0);
      if (e_rd) check("rreg", 32'(bus.o_rreg), 32'(e_reg));
      if (e_wr) check("wreg", 32'(bus.o_wreg), 32'(e_reg));
    end
  end

  task automatic set_port(input int p, input bit r, input bit w, input logic [1:0] a,
                          input logic [31:0] d);
    bus.i_req[p]            = r;
    bus.i_we[p]             = w;
    bus.i_addr[p*2 +: 2]    = a;
    bus.i_wdata[p*32 +: 32] = d;
  endtask

  task automatic wait_ack_any(input int budget, output int port, output int at);
    port = -1;
    at   = 0;
    for (int i = 0; i < budget && port < 0; i++) begin
      @(negedge clk);
      for (int p = 0; p < NP; p++) if (bus.o_ack[p]) port = p;
    end
    at = cyc;
    n_tests++;
    if (port < 0) begin
      n_fail++;
      $display("FAIL ack_timeout: got no ack within %0d cycles, required one", budget);
    end
  endtask

  int ports [8];
  int cycs [8];
  int pt, at;

  initial begin
    clk = 0;
    reset = 1;
    bus.i_req = '0; bus.i_we = '0; bus.i_addr = '0; bus.i_wdata = '0;
`ifdef REGBUS_ARB_LOCK_EN
    bus.i_lock = '0;
`endif
    rf[0] = 32'h1111_0000; rf[1] = 32'hA5A5_0001;
    rf[2] = 32'h2222_0002; rf[3] = 32'h1234_5678;
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(bus.o_ack), 32'd0);
    check("rst_rd", 32'(bus.o_rd), 32'd0);
    check("rst_wr", 32'(bus.o_wr), 32'd0);
    check("rst_rdata", bus.o_rdata, 32'd0);
    check("rst_wdata", bus.o_wdata, 32'd0);
    reset = 0;

    // single write from port 0
    set_port(0, 1, 1, 2'd2, 32'hDEAD_BEEF);
    @(negedge clk);
    check("w1_wr", 32'(bus.o_wr), 32'd1);
    check("w1_wreg", 32'(bus.o_wreg), 32'd2);
    check("w1_wdata", bus.o_wdata, 32'hDEAD_BEEF);
    @(negedge clk);
    check("w1_ack", 32'(bus.o_ack), 32'b0001);
    set_port(0, 0, 0, 2'd0, 32'd0);
    @(negedge clk);

    // single read from port 1
    set_port(1, 1, 0, 2'd3, 32'd0);
    @(negedge clk);
    check("r1_rd", 32'(bus.o_rd), 32'd1);
    check("r1_rreg", 32'(bus.o_rreg), 32'd3);
    @(negedge clk);
    check("r1_ack", 32'(bus.o_ack), 32'b0010);
    check("r1_rdata", bus.o_rdata, 32'h1234_5678);
    set_port(1, 0, 0, 2'd0, 32'd0);
    @(negedge clk);

    // back-to-back: read then write from port 0, new request at the ack edge
    set_port(0, 1, 0, 2'd1, 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("b2b_ack1", 32'(bus.o_ack), 32'b0001);
    check("b2b_rdata1", bus.o_rdata, 32'hA5A5_0001);
    set_port(0, 1, 1, 2'd0, 32'h0000_00FF);
    @(negedge clk);
    check("b2b_gap", 32'(bus.o_wr), 32'd0);
    @(negedge clk);
    check("b2b_wr", 32'(bus.o_wr), 32'd1);
    check("b2b_rdata_hold", bus.o_rdata, 32'hA5A5_0001);
    @(negedge clk);
    check("b2b_ack2", 32'(bus.o_ack), 32'b0001);
    check("b2b_rdata_hold2", bus.o_rdata, 32'hA5A5_0001);
    set_port(0, 0, 0, 2'd0, 32'd0);

    // contention from a clean reset
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    for (int p = 0; p < NP; p++) set_port(p, 1, p[0], 2'(p), 32'hC0DE_0000 + 32'(p));
    for (int i = 0; i < 8; i++) wait_ack_any(10, ports[i], cycs[i]);
    for (int p = 0; p < NP; p++) set_port(p, 0, 0, 2'd0, 32'd0);
    for (int i = 0; i < 8; i++) begin
      check("rr_order", 32'(ports[i]), 32'(i % NP));
      if (i > 0) check("ack_spacing", 32'(cycs[i] - cycs[i-1]), 32'd3);
    end
    @(negedge clk);

    // reset during ACCESS of a port-0 write
    set_port(1, 1, 0, 2'd0, 32'd0);
    wait_ack_any(10, pt, at);
    check("pre_rst_port", 32'(pt), 32'd1);
    set_port(1, 0, 0, 2'd0, 32'd0);
    @(negedge clk);
    set_port(0, 1, 1, 2'd1, 32'h5555_AAAA);
    @(negedge clk);
    check("mid_wr", 32'(bus.o_wr), 32'd1);
    reset = 1;
    @(negedge clk);
    check("mid_rst_wr", 32'(bus.o_wr), 32'd0);
    check("mid_rst_ack", 32'(bus.o_ack), 32'd0);
    reset = 0;
    set_port(3, 1, 0, 2'd2, 32'd0);
    @(negedge clk);
    check("post_rst_wr", 32'(bus.o_wr), 32'd1);
    check("post_rst_wreg", 32'(bus.o_wreg), 32'd1);
    @(negedge clk);
    check("post_rst_ack", 32'(bus.o_ack), 32'b0001);
    set_port(0, 0, 0, 2'd0, 32'd0);
    wait_ack_any(10, pt, at);
    check("post_rst_next", 32'(pt), 32'd3);
    set_port(3, 0, 0, 2'd0, 32'd0);
    @(negedge clk);

`ifdef REGBUS_ARB_LOCK_EN
    // locked read-modify-write on port 1 holds off port 0
    set_port(0, 1, 0, 2'd0, 32'd0);
    wait_ack_any(10, pt, at);
    set_port(0, 0, 0, 2'd0, 32'd0);
    @(negedge clk);
    set_port(1, 1, 0, 2'd2, 32'd0);
    bus.i_lock[1] = 1'b1;
    set_port(0, 1, 0, 2'd3, 32'd0);
    wait_ack_any(10, pt, at);
    check("lock_first", 32'(pt), 32'd1);
    set_port(1, 1, 1, 2'd2, 32'h0000_0077);
    bus.i_lock[1] = 1'b0;
    wait_ack_any(10, pt, at);
    check("lock_second", 32'(pt), 32'd1);
    set_port(1, 0, 0, 2'd0, 32'd0);
    wait_ack_any(10, pt, at);
    check("lock_release", 32'(pt), 32'd0);
    set_port(0, 0, 0, 2'd0, 32'd0);
`endif

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regbus_arbiter.md
Name: regbus_arbiter

Overview:
- Shares one register-file port (rd/rreg/rdata and wr/wreg/wdata, the same interface the AXI register bridge drives) between N_PORTS requesters.
- Typical requesters: the AXI register bridge, a local sequencer and a debug port.
- Round-robin arbitration; exactly one access in flight at a time.
- Fixed 3-cycle transaction: grant → access → ack. Reads and writes take the same time.

Parameters:
- N_PORTS, 2, number of requesters (2..8).
- R_ADDR_WIDTH, 2, register index width; must match the register file.

Ports:
- clk  in  1  sole clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- i_req  in  N_PORTS  per-port request; held until that port's o_ack.
- i_we  in  N_PORTS  per-port direction: 1 = write, 0 = read.
- i_addr  in  N_PORTS*R_ADDR_WIDTH  per-port register index; port p at slice [p*R_ADDR_WIDTH +: R_ADDR_WIDTH].
- i_wdata  in  N_PORTS*32  per-port write data; port p at slice [p*32 +: 32].
- o_ack  out  N_PORTS  one-hot, one-cycle completion pulse.
- o_rdata  out  32  read data; broadcast to all ports; valid only while o_ack is high for a read.
- o_rreg  out  R_ADDR_WIDTH  register-file read index.
- o_rd  out  1  register-file read strobe.
- i_rdata  in  32  register-file read data; valid in the cycle o_rd is high.
- o_wreg  out  R_ADDR_WIDTH  register-file write index.
- o_wdata  out  32  register-file write data.
- o_wr  out  1  register-file write strobe.

Behaviour:
- Reset values: state IDLE; o_ack, o_rd, o_wr all 0; o_rreg, o_wreg, o_wdata, o_rdata all 0; last_grant = N_PORTS-1, so port 0 wins the first arbitration.
- State machine: IDLE → ACCESS → ACK → IDLE. There are no other states.
- IDLE:
  - If any i_req bit is high, choose winner g: the first requesting port scanning upward from last_grant+1, wrapping mod N_PORTS.
  - Register at the same edge: g, last_grant <= g, the direction, o_rreg/o_wreg <= addr[g].
  - For a write, also register o_wdata <= wdata[g] and o_wr <= 1.
  - For a read, register o_rd <= 1.
  - Go to ACCESS. With no request, remain in IDLE with all strobes 0.
- ACCESS:
  - o_rd or o_wr is high for exactly this one cycle; never both.
  - On a read, capture o_rdata <= i_rdata at the end of the cycle.
  - Register o_ack[g] <= 1 and go to ACK.
- ACK:
  - o_ack[g] is high for exactly one cycle; o_rdata holds its value.
  - No arbitration happens in ACK. Return to IDLE.
- Latency: ack is 2 cycles after the IDLE cycle that samples the request. Maximum throughput is one transaction per 3 cycles.
- Requester rules:
  - Hold req/we/addr/wdata stable until ack is sampled.
  - At the ack edge, either drop req or present the next request; IDLE evaluates it on the following cycle.
  - A requester holding req continuously is re-arbitrated fairly against the other ports.
- Fairness: with all ports requesting, grants rotate 0,1,…,N_PORTS-1,0. No port waits more than N_PORTS-1 transactions.
- o_rdata is unchanged by writes and retains the last read value.
- Non-granted requests are not sampled; their inputs may change freely until they are granted.
- Reset mid-transaction: any state goes to IDLE and all outputs return to reset values. The in-flight access is abandoned with no ack, and the requester must re-issue. A strobe already high is dropped on the reset edge.
- Out-of-range N_PORTS is a compile-time error.

Optional Feature:
- Macro: REGBUS_ARB_LOCK_EN.
- Enabled: adds input port i_lock [N_PORTS], enabling atomic read-modify-write sequences.
  - A grant taken with i_lock[g]=1 sets lock_owner=g, lock_valid=1.
  - While lock_valid is set and i_req[lock_owner] is high in IDLE, the owner wins regardless of round-robin, and last_grant is not advanced.
  - The lock clears when:
    - the owner is granted with i_lock=0, or
    - the owner has i_req low in an IDLE cycle, or
    - on reset.
- Disabled: the port is absent and arbitration is pure round-robin.

Decomposition:
- Package regbus_pkg:
  - arb_state_t enum {IDLE, ACCESS, ACK}.
  - localparam MAX_PORTS = 8.
  - Port-index width function clog2 with a minimum of 1.
- Sub-module regbus_rr_pick: combinational round-robin picker.
  - Inputs: req vector, last_grant.
  - Outputs: any, grant index.
  - Reusable by other arbiters.
- The FSM, datapath registers and lock logic stay in regbus_arbiter.

Test Plan:
- Single write: port 0 writes addr=2, data=0xDEADBEEF, held from cycle 0. Expect o_wr=1, o_wreg=2, o_wdata=0xDEADBEEF in cycle 1, and o_ack=2'b01 in cycle 2.
- Single read: port 1 reads addr=3; the register-file model returns 0x12345678 while o_rd is high. Expect o_rd=1 and o_rreg=3 in cycle 1; o_ack=2'b10 and o_rdata=0x12345678 in cycle 2.
- Contention: N_PORTS=4, all ports request continuously for 8 transactions. Expect grant order 0,1,2,3,0,1,2,3, acks spaced 3 cycles apart, and o_rd and o_wr never both high.
- Reset mid-operation: assert reset during ACCESS of a port-0 write. Expect o_wr=0 the next cycle, no ack, state IDLE, then port 0 wins first after reset.
- Back-to-back: port 0 presents a new request at its ack edge while port 1 is idle. Expect the next grant in IDLE 1 cycle later, and o_rdata to retain the old read value through the write.
- Lock (REGBUS_ARB_LOCK_EN): port 1 reads then writes with i_lock=1 while port 0 requests. Expect both port-1 transactions before port 0; port 0 is granted after port 1 drops the lock.
